// File: rtl/memshare_skid_ctrl_mc.sv
// Multi-channel skid-buffer selector for SCU.memShare(): chooses the skid path per channel,
// tracks skid occupancy per channel, stalls when a buffer is full and drains after the operation.
//
// state  | meaning
// IDLE   | waiting for memShare busy; window config is latched on exit
// ACTIVE | memShare running; skid grants are made
// DRAIN  | busy has dropped; waiting for the skid buffers to empty
module memshare_skid_ctrl_mc #(
   parameter int NUM_CH            = 4,
   parameter int MAX_ALLOC_SEQ_NUM = 3,
   parameter int SKID_DEPTH        = 2,
   parameter int OUT_REG           = 0,
   parameter int WIN_W             = $clog2(MAX_ALLOC_SEQ_NUM + 2)
) (
   input  logic                                        sys_clk,
   input  logic                                        rstn,
   input  logic                                        scu_memShare_busy_i,
   input  logic                                        pipeCycle_begin_i,
   input  logic                                        isGtr_vld_i,
   input  logic [NUM_CH-1:0]                           isGtr_i,
   input  logic [WIN_W-1:0]                            cfg_b2b_len_i,
   input  logic [NUM_CH-1:0]                           skid_release_i,
   output logic [NUM_CH-1:0]                           isColAddr_skid_o,
   output logic [NUM_CH-1:0]                           skid_stall_o,
   output logic [NUM_CH*$clog2(SKID_DEPTH+1)-1:0]      occ_o,
   output logic                                        drain_o,
   output logic                                        ready_o,
   output logic                                        err_o
);

   localparam int OCC_W = $clog2(SKID_DEPTH + 1);
   localparam int HW    = MAX_ALLOC_SEQ_NUM;
   localparam logic [WIN_W-1:0] LEN_MAX  = WIN_W'(MAX_ALLOC_SEQ_NUM + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} stateT;

   stateT state, stateNext;

   logic [WIN_W-1:0] lenQ;
   logic [WIN_W-1:0] lenSat;
   logic             errQ;
   logic             errSet;

   logic [HW-1:0]    hist      [NUM_CH];
   logic [HW-1:0]    histShift [NUM_CH];
   logic [OCC_W-1:0] occ       [NUM_CH];
   logic [OCC_W-1:0] occNext   [NUM_CH];

   logic [HW:0]       win;
   logic [NUM_CH-1:0] b2b;
   logic [NUM_CH-1:0] want;
   logic [NUM_CH-1:0] dec;
   logic [NUM_CH-1:0] skidNet;
   logic [NUM_CH-1:0] stallNet;
   logic [NUM_CH-1:0] skidSel;
   logic [NUM_CH-1:0] stallSel;
   logic              relErr;
   logic              anyOcc;
   logic              occNextZero;
   logic              active;

   assign lenSat = (cfg_b2b_len_i > LEN_MAX) ? LEN_MAX : cfg_b2b_len_i;
   assign active = (state == ACTIVE);

   always_comb begin
      win         = '0;
      b2b         = '0;
      want        = '0;
      dec         = '0;
      skidNet     = '0;
      stallNet    = '0;
      relErr      = 1'b0;
      anyOcc      = 1'b0;
      occNextZero = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         histShift[c]    = '0;
         histShift[c][0] = isGtr_i[c];
         for (int k = 1; k < HW; k++) histShift[c][k] = hist[c][k-1];

         // Newest sample sits at bit 0 of the window, older history above it.
         win    = {hist[c], isGtr_i[c]};
         b2b[c] = (lenQ != '0);
         for (int k = 0; k <= HW; k++) begin
            if (k < int'(lenQ)) b2b[c] = b2b[c] & win[k];
         end

         want[c] = active & scu_memShare_busy_i & isGtr_vld_i & isGtr_i[c]
                   & ~b2b[c] & ~pipeCycle_begin_i;
         skidNet[c]  = want[c] & ((occ[c] < OCC_FULL) | skid_release_i[c]);
         stallNet[c] = want[c] & ~skidNet[c];

         dec[c] = skid_release_i[c] & (occ[c] != '0);
         relErr = relErr | (skid_release_i[c] & (occ[c] == '0));
         case ({skidNet[c], dec[c]})
            2'b10:   occNext[c] = occ[c] + OCC_W'(1);
            2'b01:   occNext[c] = occ[c] - OCC_W'(1);
            default: occNext[c] = occ[c];
         endcase
         anyOcc      = anyOcc | (occ[c] != '0);
         occNextZero = occNextZero & (occNext[c] == '0);
      end
   end

   always_comb begin
      stateNext = state;
      errSet    = relErr;
      case (state)
         IDLE:   if (scu_memShare_busy_i) stateNext = ACTIVE;
         ACTIVE: if (!scu_memShare_busy_i) stateNext = anyOcc ? DRAIN : IDLE;
         DRAIN: begin
            if (scu_memShare_busy_i) errSet = 1'b1;
            if (occNextZero) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         lenQ  <= '0;
         errQ  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            hist[c] <= '0;
            occ[c]  <= '0;
         end
      end else begin
         state <= stateNext;
         errQ  <= errQ | errSet;
         if (state == IDLE && scu_memShare_busy_i) lenQ <= lenSat;
         for (int c = 0; c < NUM_CH; c++) begin
            occ[c] <= occNext[c];
            if (state == IDLE && scu_memShare_busy_i) hist[c] <= '0;
            else if (active && isGtr_vld_i)            hist[c] <= histShift[c];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : gOutReg
         logic [NUM_CH-1:0] skidQ;
         logic [NUM_CH-1:0] stallQ;
         always_ff @(posedge sys_clk or negedge rstn) begin
            if (!rstn) begin
               skidQ  <= '0;
               stallQ <= '0;
            end else begin
               skidQ  <= skidNet;
               stallQ <= stallNet;
            end
         end
         assign skidSel  = skidQ;
         assign stallSel = stallQ;
      end else begin : gOutComb
         assign skidSel  = skidNet;
         assign stallSel = stallNet;
      end
   endgenerate

   always_comb begin
      occ_o = '0;
      for (int c = 0; c < NUM_CH; c++) occ_o[c*OCC_W +: OCC_W] = occ[c];
   end

   // Skid select is held low outside ACTIVE so nothing leaks past the operation.
   assign isColAddr_skid_o = skidSel & {NUM_CH{active}};
   assign skid_stall_o     = stallSel;
   assign drain_o          = (state == DRAIN);
   assign ready_o          = (state == IDLE);
   assign err_o            = errQ;

endmodule

// File: tb/tb_memshare_skid_ctrl_mc.sv
// Directed bench for memshare_skid_ctrl_mc; a combinational-output and a registered-output
// instance share the same stimulus.
module tb_memshare_skid_ctrl_mc;

   logic       sys_clk = 1'b0;
   logic       rstn    = 1'b0;
   logic       busy    = 1'b0;
   logic       pbegin  = 1'b0;
   logic       vld     = 1'b0;
   logic [3:0] gtr     = '0;
   logic [2:0] cfg     = '0;
   logic [3:0] rel     = '0;

   logic [3:0] skid0, stall0, skid1, stall1;
   logic [7:0] occ0, occ1;
   logic       drain0, ready0, err0, drain1, ready1, err1;

   int tests = 0;
   int fails = 0;

   always #5 sys_clk = ~sys_clk;

   memshare_skid_ctrl_mc #(.OUT_REG(0)) dut (
      .sys_clk(sys_clk), .rstn(rstn), .scu_memShare_busy_i(busy),
      .pipeCycle_begin_i(pbegin), .isGtr_vld_i(vld), .isGtr_i(gtr),
      .cfg_b2b_len_i(cfg), .skid_release_i(rel),
      .isColAddr_skid_o(skid0), .skid_stall_o(stall0), .occ_o(occ0),
      .drain_o(drain0), .ready_o(ready0), .err_o(err0));

   memshare_skid_ctrl_mc #(.OUT_REG(1)) dutReg (
      .sys_clk(sys_clk), .rstn(rstn), .scu_memShare_busy_i(busy),
      .pipeCycle_begin_i(pbegin), .isGtr_vld_i(vld), .isGtr_i(gtr),
      .cfg_b2b_len_i(cfg), .skid_release_i(rel),
      .isColAddr_skid_o(skid1), .skid_stall_o(stall1), .occ_o(occ1),
      .drain_o(drain1), .ready_o(ready1), .err_o(err1));

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clearIn();
      busy = 0; pbegin = 0; vld = 0; gtr = '0; rel = '0;
   endtask

   task automatic doReset();
      clearIn();
      rstn = 0;
      #2;
      rstn = 1;
      tick();
   endtask

   task automatic startOp(input logic [2:0] len);
      cfg  = len;
      busy = 1;
      tick();
   endtask

   task automatic test_reset();
      #2;
      tests++;
      if ({skid0, stall0, occ0, drain0, ready0, err0} !== {4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_comb: got skid=%b stall=%b occ=%h drain=%b ready=%b err=%b expected 0 0 00 0 1 0",
                  skid0, stall0, occ0, drain0, ready0, err0);
      end
      tests++;
      if ({skid1, stall1, occ1, drain1, ready1, err1} !== {4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_reg: got skid=%b stall=%b occ=%h drain=%b ready=%b err=%b expected 0 0 00 0 1 0",
                  skid1, stall1, occ1, drain1, ready1, err1);
      end
      rstn = 1;
      tick();
   endtask

   task automatic test_rule1();
      logic [2:0] seq, expSkid;
      logic [1:0] expOcc [3];
      logic       prev;
      seq = 3'b101; expSkid = 3'b101;
      expOcc[0] = 2'd1; expOcc[1] = 2'd1; expOcc[2] = 2'd2;
      prev = 1'b0;
      doReset();
      startOp(3'd3);
      tests++;
      if (ready0 !== 1'b0) begin
         fails++; $display("FAIL rule1_ready: got %b expected 0", ready0);
      end
      for (int i = 0; i < 3; i++) begin
         vld = 1; gtr = {3'b000, seq[i]};
         #2;
         tests++;
         if (skid0[0] !== expSkid[i]) begin
            fails++; $display("FAIL rule1_skid step %0d: got %b expected %b", i, skid0[0], expSkid[i]);
         end
         tests++;
         if (skid1[0] !== prev) begin
            fails++; $display("FAIL rule1_outreg_delay step %0d: got %b expected %b", i, skid1[0], prev);
         end
         tick();
         tests++;
         if (occ0[1:0] !== expOcc[i]) begin
            fails++; $display("FAIL rule1_occ step %0d: got %0d expected %0d", i, occ0[1:0], expOcc[i]);
         end
         tests++;
         if (skid1[0] !== expSkid[i]) begin
            fails++; $display("FAIL rule1_outreg step %0d: got %b expected %b", i, skid1[0], expSkid[i]);
         end
         prev = expSkid[i];
      end
   endtask

   task automatic rule2Run(input logic [2:0] len, input logic [2:0] expSkid,
                           input logic [2:0] expStall, input string tag);
      logic [1:0] expOcc [3];
      expOcc[0] = 2'd1; expOcc[1] = 2'd2; expOcc[2] = 2'd2;
      doReset();
      startOp(len);
      for (int i = 0; i < 3; i++) begin
         vld = 1; gtr = 4'b0010;
         #2;
         tests++;
         if (skid0[1] !== expSkid[i] || stall0[1] !== expStall[i]) begin
            fails++;
            $display("FAIL %s step %0d: got skid=%b stall=%b expected skid=%b stall=%b",
                     tag, i, skid0[1], stall0[1], expSkid[i], expStall[i]);
         end
         tick();
         tests++;
         if (occ0[3:2] !== expOcc[i]) begin
            fails++; $display("FAIL %s_occ step %0d: got %0d expected %0d", tag, i, occ0[3:2], expOcc[i]);
         end
         tests++;
         if (stall1[1] !== expStall[i]) begin
            fails++; $display("FAIL %s_outreg_stall step %0d: got %b expected %b", tag, i, stall1[1], expStall[i]);
         end
      end
   endtask

   task automatic test_rule2();
      rule2Run(3'd3, 3'b011, 3'b000, "rule2_len3");
      rule2Run(3'd0, 3'b011, 3'b100, "rule2_len0");
   endtask

   task automatic test_rule3();
      doReset();
      startOp(3'd3);
      vld = 1; gtr = 4'b0100; pbegin = 1;
      #2;
      tests++;
      if (skid0 !== 4'b0000) begin
         fails++; $display("FAIL rule3_begin_skid: got %b expected 0000", skid0);
      end
      tick();
      tests++;
      if (occ0 !== 8'h00) begin
         fails++; $display("FAIL rule3_begin_occ: got %h expected 00", occ0);
      end
      pbegin = 0;
      #2;
      tests++;
      if (skid0 !== 4'b0100) begin
         fails++; $display("FAIL rule3_nobegin_skid: got %b expected 0100", skid0);
      end
      tick();
      tests++;
      if (occ0 !== 8'h10 || skid1 !== 4'b0100) begin
         fails++; $display("FAIL rule3_nobegin_occ: got occ=%h regskid=%b expected 10 0100", occ0, skid1);
      end
   endtask

   task automatic test_full_release();
      doReset();
      startOp(3'd0);
      vld = 1; gtr = 4'b1000;
      tick();
      tick();
      tests++;
      if (occ0[7:6] !== 2'd2) begin
         fails++; $display("FAIL full_fill_occ: got %0d expected 2", occ0[7:6]);
      end
      rel = 4'b1000;
      #2;
      tests++;
      if (skid0[3] !== 1'b1 || stall0[3] !== 1'b0) begin
         fails++; $display("FAIL full_release_grant: got skid=%b stall=%b expected skid=1 stall=0", skid0[3], stall0[3]);
      end
      tick();
      tests++;
      if (occ0[7:6] !== 2'd2) begin
         fails++; $display("FAIL full_release_occ: got %0d expected 2", occ0[7:6]);
      end
      rel = '0;
   endtask

   task automatic test_drain();
      doReset();
      startOp(3'd0);
      vld = 1; gtr = 4'b0101;
      tick();
      gtr = 4'b0001;
      tick();
      tests++;
      if (occ0 !== 8'h12) begin
         fails++; $display("FAIL drain_setup_occ: got %h expected 12", occ0);
      end
      busy = 0; vld = 0; gtr = '0;
      tick();
      tests++;
      if (drain0 !== 1'b1 || ready0 !== 1'b0 || skid0 !== 4'b0000) begin
         fails++; $display("FAIL drain_enter: got drain=%b ready=%b skid=%b expected 1 0 0000", drain0, ready0, skid0);
      end
      busy = 1; rel = 4'b0001;
      tick();
      tests++;
      if (err0 !== 1'b1 || drain0 !== 1'b1 || occ0 !== 8'h11) begin
         fails++; $display("FAIL drain_busy_err: got err=%b drain=%b occ=%h expected 1 1 11", err0, drain0, occ0);
      end
      busy = 0; rel = 4'b0101;
      tick();
      rel = '0;
      tests++;
      if (ready0 !== 1'b1 || drain0 !== 1'b0 || occ0 !== 8'h00 || err0 !== 1'b1) begin
         fails++; $display("FAIL drain_exit: got ready=%b drain=%b occ=%h err=%b expected 1 0 00 1", ready0, drain0, occ0, err0);
      end
   endtask

   task automatic test_err_release();
      doReset();
      tests++;
      if (err0 !== 1'b0) begin
         fails++; $display("FAIL err_cleared_by_reset: got %b expected 0", err0);
      end
      rel = 4'b0010;
      tick();
      rel = '0;
      tests++;
      if (err0 !== 1'b1 || occ0 !== 8'h00) begin
         fails++; $display("FAIL err_empty_release: got err=%b occ=%h expected 1 00", err0, occ0);
      end
      tick();
      tests++;
      if (err0 !== 1'b1) begin
         fails++; $display("FAIL err_sticky: got %b expected 1", err0);
      end
   endtask

   task automatic test_async_reset();
      doReset();
      startOp(3'd2);
      vld = 1; gtr = 4'b0001;
      tick();
      tests++;
      if (occ0 !== 8'h01) begin
         fails++; $display("FAIL areset_setup_occ: got %h expected 01", occ0);
      end
      #1;
      rstn = 0;
      #1;
      tests++;
      if ({skid0, stall0, occ0, drain0, ready0, err0} !== {4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL areset_immediate: got skid=%b stall=%b occ=%h drain=%b ready=%b err=%b expected 0 0 00 0 1 0",
                  skid0, stall0, occ0, drain0, ready0, err0);
      end
      tests++;
      if (skid1 !== 4'h0 || occ1 !== 8'h00 || ready1 !== 1'b1) begin
         fails++; $display("FAIL areset_immediate_reg: got skid=%b occ=%h ready=%b expected 0 00 1", skid1, occ1, ready1);
      end
      clearIn();
      rstn = 1;
      tick();
      startOp(3'd2);
      vld = 1; gtr = 4'b0001;
      #2;
      tests++;
      if (skid0[0] !== 1'b1) begin
         fails++; $display("FAIL areset_hist_cleared: got %b expected 1", skid0[0]);
      end
      tick();
      gtr = 4'b0001;
      #2;
      tests++;
      if (skid0[0] !== 1'b0) begin
         fails++; $display("FAIL areset_b2b_len2: got %b expected 0", skid0[0]);
      end
      tick();
      clearIn();
   endtask

   initial begin
      test_reset();
      test_rule1();
      test_rule2();
      test_rule3();
      test_full_release();
      test_drain();
      test_err_release();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
